// File: rtl/dcj11_bus_master.sv
// DCJ11-style bus cycle sequencer: multiplexed DAL address (low/high word),
// then a read or write data phase with NXM abort, then one recovery cycle.
module dcj11_bus_master #(
  parameter int unsigned ADDR_CYC = 2,
  parameter int unsigned DATA_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [3:0]  req_aio,
  input  logic [1:0]  req_bs,
  input  logic [21:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        nxm_err,
  output logic [15:0] dal_out,
  output logic        dal_oe,
  input  logic [15:0] dal_in,
  output logic        ale_n,
  output logic        sctl_n,
  output logic        bufctl_n,
  input  logic        nxm_n,
  output logic [2:0]  dbg_state
);

  // Handshake: req is sampled only while IDLE. busy rises the cycle after
  // acceptance and stays high through RECOVER, where done pulses for one
  // cycle with nxm_err/rdata valid; requests seen while busy are dropped.

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_LO = 3'd1;
  localparam logic [2:0] S_ADDR_HI = 3'd2;
  localparam logic [2:0] S_DATA_RD = 3'd3;
  localparam logic [2:0] S_DATA_WR = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  localparam logic [3:0] ADDR_LD = 4'(ADDR_CYC - 1);
  localparam logic [3:0] DATA_LD = 4'(DATA_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  aio_q, aio_d;
  logic [1:0]  bs_q, bs_d;
  logic [21:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        nxm_err_q, nxm_err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] dal_out_q, dal_out_d;
  logic        dal_oe_q, dal_oe_d;
  logic        ale_n_q, ale_n_d;
  logic        sctl_n_q, sctl_n_d;
  logic        bufctl_n_q, bufctl_n_d;
  logic [15:0] hi_word;

  // Next state, counter and captured transaction fields.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aio_d     = aio_q;
    bs_d      = bs_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    nxm_err_d = nxm_err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          aio_d   = req_aio;
          bs_d    = req_bs;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_ADDR_LO;
          cnt_d   = ADDR_LD;
        end
      end
      S_ADDR_LO: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ADDR_HI;
          cnt_d   = ADDR_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ADDR_HI: begin
        if (cnt_q == 4'd0) begin
          if (aio_q == 4'b1111) begin
            state_d   = S_RECOVER;
            cnt_d     = 4'd0;
            nxm_err_d = 1'b0;
          end else begin
            state_d = aio_q[3] ? S_DATA_RD : S_DATA_WR;
            cnt_d   = DATA_LD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DATA_RD, S_DATA_WR: begin
        if (!nxm_n) begin
          // Abort leaves rdata untouched even on the last data cycle.
          state_d   = S_RECOVER;
          cnt_d     = 4'd0;
          nxm_err_d = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d   = S_RECOVER;
          nxm_err_d = 1'b0;
          if (state_q == S_DATA_RD) rdata_d = dal_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECOVER: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    hi_word        = '0;
    hi_word[1]     = aio_d[3];
    hi_word[15]    = aio_d[2];
    hi_word[14]    = aio_d[1];
    hi_word[13]    = aio_d[0];
    hi_word[6]     = bs_d[0];
    hi_word[7]     = bs_d[1];
    hi_word[8]     = addr_d[21];
    hi_word[0]     = addr_d[20];
    hi_word[9]     = addr_d[19];
    hi_word[12:10] = addr_d[18:16];
  end

  // Pin values are decoded from the next state and registered, so the
  // strobes come straight off flops and never glitch.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_RECOVER);
    ale_n_d    = 1'b1;
    sctl_n_d   = 1'b1;
    bufctl_n_d = 1'b1;
    dal_oe_d   = 1'b0;
    dal_out_d  = '0;
    case (state_d)
      S_ADDR_LO: begin
        ale_n_d   = 1'b0;
        dal_oe_d  = 1'b1;
        dal_out_d = addr_d[15:0];
      end
      S_ADDR_HI: begin
        ale_n_d   = 1'b0;
        dal_oe_d  = 1'b1;
        dal_out_d = hi_word;
      end
      S_DATA_RD: begin
        ale_n_d    = 1'b0;
        sctl_n_d   = 1'b0;
        bufctl_n_d = 1'b0;
      end
      S_DATA_WR: begin
        ale_n_d   = 1'b0;
        sctl_n_d  = 1'b0;
        dal_oe_d  = 1'b1;
        dal_out_d = wdata_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      aio_q      <= '0;
      bs_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      nxm_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dal_out_q  <= '0;
      dal_oe_q   <= 1'b0;
      ale_n_q    <= 1'b1;
      sctl_n_q   <= 1'b1;
      bufctl_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      aio_q      <= aio_d;
      bs_q       <= bs_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      nxm_err_q  <= nxm_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dal_out_q  <= dal_out_d;
      dal_oe_q   <= dal_oe_d;
      ale_n_q    <= ale_n_d;
      sctl_n_q   <= sctl_n_d;
      bufctl_n_q <= bufctl_n_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign nxm_err   = nxm_err_q;
  assign dal_out   = dal_out_q;
  assign dal_oe    = dal_oe_q;
  assign ale_n     = ale_n_q;
  assign sctl_n    = sctl_n_q;
  assign bufctl_n  = bufctl_n_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dcj11_bus_master.sv
// Bench for dcj11_bus_master: directed and random bus cycles compared each
// clock against a cycle-index model of the bus phases.
module tb_dcj11_bus_master;

  localparam int A = 2;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  req_aio = '0;
  logic [1:0]  req_bs = '0;
  logic [21:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        busy, done, nxm_err, dal_oe, ale_n, sctl_n, bufctl_n;
  logic [15:0] rdata, dal_out;
  logic [15:0] dal_in = '0;
  logic        nxm_n = 1'b1;
  logic [2:0]  dbg_state;

  dcj11_bus_master #(.ADDR_CYC(A), .DATA_CYC(D)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_aio(req_aio), .req_bs(req_bs),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
    .rdata(rdata), .nxm_err(nxm_err), .dal_out(dal_out), .dal_oe(dal_oe),
    .dal_in(dal_in), .ale_n(ale_n), .sctl_n(sctl_n), .bufctl_n(bufctl_n),
    .nxm_n(nxm_n), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [15:0] model_rdata = '0;
  logic        model_nxm = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] addr_hi_word(input logic [3:0] aio, input logic [1:0] bs,
                                               input logic [21:0] addr);
    logic [15:0] w;
    w = '0;
    w[1] = aio[3]; w[15] = aio[2]; w[14] = aio[1]; w[13] = aio[0];
    w[6] = bs[0];  w[7] = bs[1];
    w[8] = addr[21]; w[0] = addr[20]; w[9] = addr[19];
    w[10] = addr[16]; w[11] = addr[17]; w[12] = addr[18];
    return w;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_strobes"}, 32'({ale_n, sctl_n, bufctl_n}), 32'd7);
    check_eq({tag, "_dal_oe"}, 32'(dal_oe), 32'd0);
    check_eq({tag, "_dal_out"}, 32'(dal_out), 32'd0);
    check_eq({tag, "_nxm_err"}, 32'(nxm_err), 32'(model_nxm));
    check_eq({tag, "_rdata"}, 32'(rdata), 32'(model_rdata));
  endtask

  // driver: call at a negedge with the DUT idle (or entering idle next edge)
  task automatic do_txn(input logic [3:0] aio, input logic [1:0] bs, input logic [21:0] addr,
                        input logic [15:0] wdata, input int nxm_at, input bit b2b,
                        input logic [15:0] rd_val);
    bit nio   = (aio == 4'b1111);
    bit rd    = aio[3] && !nio;
    bit abort = !nio && (nxm_at > 0);
    int dlen  = nio ? 0 : (abort ? nxm_at : D);
    int len   = 2 * A + dlen + 1;
    logic [16:0] res;
    logic [15:0] exp_dal;
    bit lo, hi, dat;
    int j;
    if (abort || !rd) res = {abort, model_rdata};
    else              res = {1'b0, rd_val};
    exp_q.push_back(res);
    req_aio = aio; req_bs = bs; req_addr = addr; req_wdata = wdata; req = 1'b1;
    @(posedge clk);
    #1;
    if (b2b) begin
      req_aio = 4'($urandom); req_bs = 2'($urandom);
      req_addr = 22'($urandom); req_wdata = 16'($urandom);
    end else begin
      req = 1'b0;
    end
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      lo  = (k <= A);
      hi  = (k > A) && (k <= 2 * A);
      dat = (k > 2 * A) && (k < len);
      exp_dal = lo ? addr[15:0] : hi ? addr_hi_word(aio, bs, addr) : (dat && !rd) ? wdata : 16'h0;
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("done", 32'(done), 32'(k == len));
      check_eq("ale_n", 32'(ale_n), 32'(!(lo || hi || dat)));
      check_eq("sctl_n", 32'(sctl_n), 32'(!dat));
      check_eq("bufctl_n", 32'(bufctl_n), 32'(!(dat && rd)));
      check_eq("dal_oe", 32'(dal_oe), 32'(lo || hi || (dat && !rd)));
      check_eq("dal_out", 32'(dal_out), 32'(exp_dal));
      if (k == len) begin
        res = exp_q.pop_front();
        check_eq("result", 32'({nxm_err, rdata}), 32'(res));
        model_nxm   = res[16];
        model_rdata = res[15:0];
      end else begin
        check_eq("nxm_hold", 32'(nxm_err), 32'(model_nxm));
        check_eq("rdata_hold", 32'(rdata), 32'(model_rdata));
      end
      dal_in = 16'($urandom);
      nxm_n  = 1'($urandom_range(0, 1));
      if (dat) begin
        j = k - 2 * A;
        nxm_n = (j == nxm_at) ? 1'b0 : 1'b1;
        if (rd && j == dlen) dal_in = rd_val;
      end
    end
    @(negedge clk);
    check_idle("post");
  endtask

  initial begin
    logic [3:0] aio;
    int kind, nxm_at, gap;
    bit b2b, prev_b2b;

    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    // directed cycles; the first req is accepted on the first edge after release
    do_txn(4'b1001, 2'b00, 22'o00001000, 16'h0000, 0, 1'b0, 16'h1234);
    do_txn(4'b0001, 2'b10, 22'o17777566, 16'h0041, 0, 1'b0, 16'h0000);
    do_txn(4'b1001, 2'b00, 22'o17760000, 16'h0000, 1, 1'b0, 16'hBEEF);
    do_txn(4'b1111, 2'b01, 22'o12345670, 16'h5555, 0, 1'b0, 16'h0000);
    do_txn(4'b1010, 2'b11, 22'o00777777, 16'h0000, 0, 1'b1, 16'hA5A5);
    do_txn(4'b0110, 2'b01, 22'o13572460, 16'h7E01, 3, 1'b0, 16'h0000);

    // reset in the middle of a write data phase
    req_aio = 4'b0000; req_bs = 2'b00; req_addr = 22'o01234567; req_wdata = 16'hC3C3;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    nxm_n = 1'b1;
    repeat (2 * A + 1) @(negedge clk);
    check_eq("wr_pre_reset_oe", 32'(dal_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_rdata = '0;
    model_nxm   = 1'b0;
    check_idle("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("after_reset");
    end

    // random cycles
    prev_b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0)      aio = 4'b1111;
      else if (kind == 1) aio = {1'b1, 3'($urandom_range(0, 6))};
      else                aio = {1'b0, 3'($urandom)};
      nxm_at = (kind != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, D) : 0;
      b2b = ($urandom_range(0, 1) == 1) && (i < 39);
      if (!prev_b2b) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_idle("gap");
        end
      end
      do_txn(aio, 2'($urandom), 22'($urandom), 16'($urandom), nxm_at, b2b, 16'($urandom));
      prev_b2b = b2b;
    end
    req = 1'b0;
    @(negedge clk);
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
